// File: rtl/fwht_stage_sink.sv
// rtl/fwht_stage_sink.sv - ping-pong block sink for one FWHT butterfly stage
// Optional macro FWHT_SINK_REORDER_EN: interleave sums/differences on write.
module fwht_stage_sink #(
  parameter int M_WIDTH = 2,
  parameter int D_WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [D_WIDTH-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [D_WIDTH-1:0] o_data,
  output logic               o_last,
  output logic               o_overflow
);

  localparam int N = 1 << M_WIDTH;
  localparam logic [M_WIDTH-1:0] CNT_MAX = M_WIDTH'(N - 1);

  logic [D_WIDTH-1:0] r_mem [0:1][0:N-1];
  logic [1:0]         r_full;
  logic               r_wb;
  logic               r_rb;
  logic [M_WIDTH-1:0] r_wcnt;
  logic [M_WIDTH-1:0] r_rcnt;
  logic               r_overflow;

  logic               w_wr;
  logic               w_rd;
  logic               w_wlast;
  logic               w_rlast;
  logic [M_WIDTH-1:0] w_waddr;
  logic [1:0]         w_full_nxt;

  // A write only ever targets a non-full bank, so it can never collide with a drain.
  assign w_wr    = i_valid && !r_full[r_wb];
  assign w_rd    = r_full[r_rb] && i_ready;
  assign w_wlast = (r_wcnt == CNT_MAX);
  assign w_rlast = (r_rcnt == CNT_MAX);

`ifdef FWHT_SINK_REORDER_EN
  always_comb begin
    w_waddr = '0;
    for (int i = 0; i < M_WIDTH; i++) begin
      w_waddr[(i + 1) % M_WIDTH] = r_wcnt[i];
    end
  end
`else
  assign w_waddr = r_wcnt;
`endif

  always_comb begin
    w_full_nxt = r_full;
    if (w_rd && w_rlast) w_full_nxt[r_rb] = 1'b0;
    if (w_wr && w_wlast) w_full_nxt[r_wb] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && w_wr) r_mem[r_wb][w_waddr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_full     <= 2'b00;
      r_wb       <= 1'b0;
      r_rb       <= 1'b0;
      r_wcnt     <= '0;
      r_rcnt     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr) begin
        r_wcnt <= r_wcnt + M_WIDTH'(1);
        if (w_wlast) r_wb <= ~r_wb;
      end
      if (i_valid && r_full[r_wb]) r_overflow <= 1'b1;
      if (w_rd) begin
        r_rcnt <= r_rcnt + M_WIDTH'(1);
        if (w_rlast) r_rb <= ~r_rb;
      end
    end
  end

  assign o_valid    = r_full[r_rb];
  assign o_data     = r_mem[r_rb][r_rcnt];
  assign o_last     = r_full[r_rb] && w_rlast;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_fwht_stage_sink.sv
// tb/tb_fwht_stage_sink.sv - directed self-checking bench for fwht_stage_sink
// Expected order follows FWHT_SINK_REORDER_EN when defined.
module tb_fwht_stage_sink;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_valid = 1'b0;
  logic [15:0] i_data = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [15:0] o_data;
  logic        o_last;
  logic        o_overflow;

  int total = 0;
  int bad = 0;

  logic [15:0] out_q [$];
  logic        last_q [$];
  int          exp_q [$];

`ifdef FWHT_SINK_REORDER_EN
  int perm [4] = '{0, 2, 1, 3};
`else
  int perm [4] = '{0, 1, 2, 3};
`endif

  fwht_stage_sink #(.M_WIDTH(2), .D_WIDTH(16)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_last     (o_last),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (!i_reset && o_valid && i_ready) begin
      out_q.push_back(o_data);
      last_q.push_back(o_last);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic send(input int v);
    @(posedge i_clk);
    #1;
    i_valid = 1'b1;
    i_data  = v[15:0];
  endtask

  task automatic idle();
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    out_q.delete();
    last_q.delete();
    exp_q.delete();
  endtask

  task automatic push_block(input int v0, input int v1, input int v2, input int v3);
    int v [4];
    v = '{v0, v1, v2, v3};
    for (int k = 0; k < 4; k++) exp_q.push_back(v[perm[k]]);
  endtask

  task automatic drain_check(input string tag, input int n);
    for (int c = 0; c < 300 && out_q.size() < n; c++) @(posedge i_clk);
    repeat (3) @(posedge i_clk);
    chk({tag, "_count"}, out_q.size(), n);
    for (int k = 0; k < n && out_q.size() > 0 && exp_q.size() > 0; k++) begin
      chk({tag, "_data"}, out_q.pop_front(), exp_q.pop_front());
      chk({tag, "_last"}, last_q.pop_front(), (k % 4) == 3);
    end
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    chk("rst_valid", o_valid, 0);
    chk("rst_last", o_last, 0);
    chk("rst_ovf", o_overflow, 0);

    // basic ordering and latency
    i_ready = 1'b1;
    send(10); send(20); send(30); send(40);
    chk("lat_before", o_valid, 0);
    idle();
    chk("lat_after", o_valid, 1);
    chk("lat_first", o_data, 10);
    push_block(10, 20, 30, 40);
    drain_check("order", 4);

    // hold under backpressure
    do_reset();
    i_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    idle();
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      chk("hold_valid", o_valid, 1);
      chk("hold_data", o_data, 1);
      chk("hold_last", o_last, 0);
    end
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    push_block(1, 2, 3, 4);
    drain_check("hold", 4);

    // overflow with both banks full
    do_reset();
    i_ready = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      send(i);
      if (i == 9) chk("ovf_at8", o_overflow, 0);
      if (i == 10) chk("ovf_at9", o_overflow, 1);
    end
    idle();
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    push_block(1, 2, 3, 4);
    push_block(5, 6, 7, 8);
    drain_check("ovf", 8);
    chk("ovf_sticky", o_overflow, 1);

    // reset mid-block discards partial data
    do_reset();
    i_ready = 1'b1;
    send(5); send(6);
    do_reset();
    chk("mid_rst_ovf", o_overflow, 0);
    send(50); send(60); send(70); send(80);
    idle();
    push_block(50, 60, 70, 80);
    drain_check("midrst", 4);
    chk("midrst_ovf", o_overflow, 0);

    // continuous stream with simultaneous fill/drain
    do_reset();
    i_ready = 1'b1;
    for (int i = 0; i < 64; i++) send(100 + i);
    idle();
    for (int b = 0; b < 16; b++) push_block(100 + 4*b, 101 + 4*b, 102 + 4*b, 103 + 4*b);
    drain_check("stream", 64);
    chk("stream_ovf", o_overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=%0d exp=%0d", 1, 0);
    $fatal(1, "watchdog");
  end

endmodule
